// File: rtl/instr_track_pkg.sv
// Shared core definitions: opcode constants used by the hazard controller,
// the NOP encoding and the per-stage tracking record.
package instr_track_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // addi x0,x0,0 with the two low bits dropped
  localparam logic [29:0] NOP_INSTR = 30'h0000004;

  typedef struct packed {
    logic [29:0] instr;
    logic        valid;
  } stage_t;

  // Bubbles carry the NOP so the hazard controller sees rd = x0.
  localparam stage_t BUBBLE = '{instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/instr_track_perf_cnt.sv
// 32-bit wrapping event counter with increment enable and async reset.
module instr_track_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= 32'd0;
    else if (i_inc)
      r_count <= r_count + 32'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_track.sv
// Pipeline instruction tracker: per-stage instruction/valid state feeding the
// hazard controller, with stall bubbles, redirect flushes and fetch handshake.
module instr_track
  import instr_track_pkg::*;
#(
  parameter int PIPELINE_LENGTH = 4,
  parameter int FLUSH_DEPTH     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_valid,
  input  logic [29:0]                       fetch_instr,
  output logic                              fetch_ready,
  input  logic                              stall,
  input  logic                              flush,
  output logic [PIPELINE_LENGTH-1:0][29:0]  instr,
  output logic [PIPELINE_LENGTH-1:0]        valid,
  output logic                              retire_valid,
  output logic [31:0]                       retire_count,
  output logic [31:0]                       bubble_count
);

  stage_t r_stage [PIPELINE_LENGTH];
  stage_t w_next  [PIPELINE_LENGTH];
  logic   w_transfer;
  logic   w_bubbleInc;

  assign fetch_ready = !stall && !flush && !rst;
  assign w_transfer  = fetch_valid && fetch_ready;
  assign w_bubbleInc = stall && !flush;

  // Flush beats stall; stage 0 only holds on a pure stall.
  always_comb begin
    w_next[0] = BUBBLE;
    if (!flush && stall)
      w_next[0] = r_stage[0];
    else if (w_transfer)
      w_next[0] = '{instr: fetch_instr, valid: 1'b1};
    for (int i = 1; i < PIPELINE_LENGTH; i++) begin
      w_next[i] = r_stage[i-1];
      if ((flush && i <= FLUSH_DEPTH) || (!flush && stall && i == 1))
        w_next[i] = BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE_LENGTH; i++)
        r_stage[i] <= BUBBLE;
    end else begin
      for (int i = 0; i < PIPELINE_LENGTH; i++)
        r_stage[i] <= w_next[i];
    end
  end

  for (genvar g = 0; g < PIPELINE_LENGTH; g++) begin : g_out
    assign instr[g] = r_stage[g].instr;
    assign valid[g] = r_stage[g].valid;
  end

  assign retire_valid = r_stage[PIPELINE_LENGTH-1].valid;

  instr_track_perf_cnt u_retireCnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (retire_valid),
    .o_count (retire_count)
  );

  instr_track_perf_cnt u_bubbleCnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_bubbleInc),
    .o_count (bubble_count)
  );

endmodule

// File: doc/instr_track.md
Name: instr_track

Overview:
- Pipeline instruction tracker; the producer side of the hazard-controller interface.
- Holds the instruction word and a valid bit for every pipeline stage and drives the per-stage instruction array the hazard controller inspects.
- Consumes the hazard controller's stall, inserts bubbles, handles redirect flushes, and handshakes with fetch.
- Sits between fetch and decode in the core.

Parameters:
- PIPELINE_LENGTH, 4, number of tracked stages; index 0 = decode, index PIPELINE_LENGTH-1 = writeback.
- FLUSH_DEPTH, 1, index of the stage that raises flush (execute); legal range 1..PIPELINE_LENGTH-2.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- fetch_valid  in  1  fetch_instr holds a valid instruction.
- fetch_instr  in  30  instruction bits [31:2] from fetch.
- fetch_ready  out  1  tracker accepts fetch_instr this cycle.
- stall  in  1  hazard stall for the instruction in stage 0.
- flush  in  1  redirect taken by the instruction in stage FLUSH_DEPTH.
- instr  out  30 x PIPELINE_LENGTH  per-stage instruction bits [31:2], feeds the hazard controller.
- valid  out  PIPELINE_LENGTH  per-stage valid; 0 marks a bubble.
- retire_valid  out  1  valid[PIPELINE_LENGTH-1].
- retire_count  out  32  retired instructions.
- bubble_count  out  32  stall cycles.

Behaviour:
- Reset (async, active-high): every instr[i] = NOP (addi x0,x0,0; bits [31:2] = 30'h0000004), every valid[i] = 0, both counters = 0. fetch_ready = 0 while rst is high.
- fetch_ready = !stall & !flush & !rst, combinational.
- A transfer happens when fetch_valid & fetch_ready.
- All state updates on the rising clk edge; outputs come directly from registers, except fetch_ready and retire_valid.
- Priority per cycle is flush > stall > normal.
- Normal (no stall, no flush):
  - stage[i] <= stage[i-1] for i >= 1.
  - stage[0] <= {fetch_instr, 1} on a transfer, otherwise {NOP, 0}.
- Stall (no flush):
  - stage[0] holds its contents.
  - stage[1] <= {NOP, 0} (bubble).
  - stage[i] <= stage[i-1] for i >= 2.
  - Fetch is not accepted.
  - bubble_count += 1.
- Flush:
  - stages 0..FLUSH_DEPTH <= {NOP, 0}, discarding wrong-path instructions.
  - stage[i] <= stage[i-1] for i > FLUSH_DEPTH; the redirecting instruction continues.
  - Fetch is not accepted.
  - flush overrides a simultaneous stall; bubble_count is not incremented.
- Retire: retire_valid = valid[PIPELINE_LENGTH-1]. retire_count += 1 on every clock edge where retire_valid is 1, independent of stall and flush, since the last stage always advances.
- Counters wrap modulo 2^32.
- A held stage 0 under stall keeps both its instr and its valid bit.
- A continuous stall drains the older stages and fills them with bubbles; the hazard condition clears once the producer retires.
- Reset asserted mid-operation clears all state immediately, regardless of clk. On the first edge after rst deasserts, normal advance resumes.
- A bubble always carries the NOP encoding, so the hazard controller sees rd = x0 and never stalls on it.

Decomposition:
- Shared core package holds:
  - the 5-bit opcode constants (LOAD, JALR, JAL, OP_IMM, OP, AUIPC, LUI, SYSTEM), already shared with the hazard controller;
  - the NOP_INSTR constant (30'h0000004);
  - a stage struct {instr[31:2], valid}.
- One natural sub-module, perf_cnt: a 32-bit wrapping counter with an increment enable and async reset. It is instantiated twice, for retire_count and bubble_count.

Test Plan:
- Reset: hold rst = 1 for 3 cycles, then release with fetch_valid = 0 for 4 cycles -> all valid = 0, all instr = 30'h0000004, fetch_ready = 1 after release, retire_count = 0.
- Straight-line flow: send 0x00100293>>2 (30'h00400A4), then 30'h00800A4 on consecutive cycles, no stall -> each appears in stage 0, then stages 1, 2, 3 on successive cycles; retire_valid pulses twice; retire_count = 2.
- Stall: stall = 1 for 2 cycles while stage 0 = 30'h00400A4 -> stage 0 holds; stage 1 shows NOP with valid = 0 both cycles; fetch_ready = 0; bubble_count = 2.
- Flush: stages 0/1 valid with A/B, flush = 1 -> next cycle stages 0 and 1 = NOP (valid 0), stage 2 = B, and A is never retired.
- Flush with stall in the same cycle -> flush behaviour only; bubble_count unchanged; fetch_ready = 0.
- Counter wrap and reset mid-run: force retire_count to 32'hFFFFFFFF, retire one instruction -> 0. Assert rst between clock edges while the pipeline is full -> every output resets immediately, without waiting for clk.
